// File: rtl/mc_alu.sv
`default_nettype none
// ============================================================================
//  Module   : mc_alu
//  Purpose  : Multi-cycle ALU. FORWARD/ADD/AND/OR/SUB finish in one cycle;
//             MUL (shift-add) and SLL/SRA (one bit per cycle) iterate in EXEC.
//             RESULT/ZERO/CARRY are registered and qualified by a DONE pulse.
//  Revision : 1.0  initial release
// ============================================================================
module mc_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       select_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             busy_o,
    output logic             done_o
);

    // Counter must hold WIDTH itself (MUL iteration count / saturated shift).
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_exec = 1'b1;

    localparam logic [2:0] c_op_fwd = 3'b000;
    localparam logic [2:0] c_op_add = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_or  = 3'b011;
    localparam logic [2:0] c_op_sub = 3'b100;
    localparam logic [2:0] c_op_mul = 3'b101;
    localparam logic [2:0] c_op_sll = 3'b110;
    localparam logic [2:0] c_op_sra = 3'b111;

    localparam logic [WIDTH-1:0] c_sat_w    = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    c_cnt_full = CW'(WIDTH);
    localparam logic [CW-1:0]    c_cnt_one  = CW'(1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [CW-1:0]    w_shamt;
    logic             w_is_shift;
    logic             w_launch_exec;
    logic [WIDTH-1:0] w_step;
    logic             w_last_iter;

    // Single-cycle adder/subtractor with the extra bit kept for CARRY.
    assign w_sum  = {1'b0, data1_i} + {1'b0, data2_i};
    assign w_diff = {1'b0, data1_i} - {1'b0, data2_i};

    // Shift amounts of WIDTH or more saturate to WIDTH iterations.
    assign w_shamt = (data2_i >= c_sat_w) ? c_cnt_full : data2_i[CW-1:0];

    assign w_is_shift    = (select_i == c_op_sll) || (select_i == c_op_sra);
    assign w_launch_exec = start_i &&
                           ((select_i == c_op_mul) || (w_is_shift && (w_shamt != '0)));
    assign w_last_iter   = (cnt_q == c_cnt_one);

    // One EXEC iteration of the latched operation.
    always_comb begin
        w_step = acc_q;
        case (op_q)
            c_op_mul: w_step = acc_q + (b_q[0] ? a_q : '0);
            c_op_sll: w_step = {acc_q[WIDTH-2:0], 1'b0};
            c_op_sra: w_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default:  w_step = acc_q;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enter EXEC only for iterative ops, leave on the last iteration.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: if (w_launch_exec) state_d = c_st_exec;
            c_st_exec: if (w_last_iter)   state_d = c_st_idle;
            default:   state_d = c_st_idle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy_o = (state_q == c_st_exec);
    end

    // Datapath next state: operand latch, iteration and result write-back.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        carry_d  = carry_q;
        done_d   = 1'b0;

        if (state_q == c_st_idle) begin
            if (start_i) begin
                a_d  = data1_i;
                b_d  = data2_i;
                op_d = select_i;
                case (select_i)
                    c_op_mul: begin
                        acc_d = '0;
                        cnt_d = c_cnt_full;
                    end
                    c_op_sll, c_op_sra: begin
                        if (w_shamt == '0) begin
                            result_d = data1_i;
                            carry_d  = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            acc_d = data1_i;
                            cnt_d = w_shamt;
                        end
                    end
                    c_op_add: begin
                        result_d = w_sum[WIDTH-1:0];
                        carry_d  = w_sum[WIDTH];
                        done_d   = 1'b1;
                    end
                    c_op_sub: begin
                        // No borrow out of the top bit means A >= B unsigned.
                        result_d = w_diff[WIDTH-1:0];
                        carry_d  = ~w_diff[WIDTH];
                        done_d   = 1'b1;
                    end
                    c_op_and: begin
                        result_d = data1_i & data2_i;
                        carry_d  = 1'b0;
                        done_d   = 1'b1;
                    end
                    c_op_or: begin
                        result_d = data1_i | data2_i;
                        carry_d  = 1'b0;
                        done_d   = 1'b1;
                    end
                    default: begin
                        // FORWARD passes operand B through.
                        result_d = data2_i;
                        carry_d  = 1'b0;
                        done_d   = 1'b1;
                    end
                endcase
            end
        end else begin
            acc_d = w_step;
            cnt_d = cnt_q - c_cnt_one;
            if (op_q == c_op_mul) begin
                // Multiplicand moves up as the multiplier is consumed LSB first.
                a_d = {a_q[WIDTH-2:0], 1'b0};
                b_d = {1'b0, b_q[WIDTH-1:1]};
            end
            if (w_last_iter) begin
                result_d = w_step;
                carry_d  = 1'b0;
                done_d   = 1'b1;
            end
        end

        zero_d = (result_d == '0);
    end

    // Datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign carry_o  = carry_q;
    assign done_o   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_alu
//  Purpose  : Self-checking bench for mc_alu (WIDTH=8 and WIDTH=16 instances).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_alu;

    typedef struct {
        logic [15:0] r;
        logic        z;
        logic        c;
    } exp_t;

    typedef struct {
        bit          w16;
        logic [2:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        z;
        logic        c;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        st8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [2:0]  sel8 = '0;
    logic [7:0]  res8;
    logic        z8, c8, busy8, done8;

    logic        st16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [2:0]  sel16 = '0;
    logic [15:0] res16;
    logic        z16, c16, busy16, done16;

    int total = 0;
    int bad   = 0;

    exp_t q8[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    mc_alu #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .reset_i(rst), .start_i(st8),
        .data1_i(a8), .data2_i(b8), .select_i(sel8),
        .result_o(res8), .zero_o(z8), .carry_o(c8),
        .busy_o(busy8), .done_o(done8)
    );

    mc_alu #(.WIDTH(16)) u_dut16 (
        .clk_i(clk), .reset_i(rst), .start_i(st16),
        .data1_i(a16), .data2_i(b16), .select_i(sel16),
        .result_o(res16), .zero_o(z16), .carry_o(c16),
        .busy_o(busy16), .done_o(done16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every DONE pulse pops one expected record.
    always @(negedge clk) begin
        if (done8) begin
            total++;
            if (busy8) begin
                bad++;
                $display("FAIL done8_with_busy: busy=1 want 0");
            end else if (q8.size() == 0) begin
                bad++;
                $display("FAIL done8_unexpected: DONE with no pending op");
            end else begin
                exp_t e;
                e = q8.pop_front();
                if (res8 !== e.r[7:0] || z8 !== e.z || c8 !== e.c) begin
                    bad++;
                    $display("FAIL sb8: got r=0x%0h z=%0b c=%0b want r=0x%0h z=%0b c=%0b",
                             res8, z8, c8, e.r[7:0], e.z, e.c);
                end
            end
        end
        if (done16) begin
            total++;
            if (busy16) begin
                bad++;
                $display("FAIL done16_with_busy: busy=1 want 0");
            end else if (q16.size() == 0) begin
                bad++;
                $display("FAIL done16_unexpected: DONE with no pending op");
            end else begin
                exp_t e;
                e = q16.pop_front();
                if (res16 !== e.r || z16 !== e.z || c16 !== e.c) begin
                    bad++;
                    $display("FAIL sb16: got r=0x%0h z=%0b c=%0b want r=0x%0h z=%0b c=%0b",
                             res16, z16, c16, e.r, e.z, e.c);
                end
            end
        end
    end

    function automatic logic cur_done(input bit w16);
        return w16 ? done16 : done8;
    endfunction

    function automatic logic cur_busy(input bit w16);
        return w16 ? busy16 : busy8;
    endfunction

    // Wait for DONE after a START edge; checks latency and BUSY cycle count.
    task automatic wait_done(input bit w16, input int exp_lat, input string name);
        int  n = 0;
        int  nb = 0;
        bit  seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (cur_busy(w16)) nb++;
            if (cur_done(w16)) seen = 1;
            else n++;
        end
        check({name, "_latency"}, n, exp_lat);
        check({name, "_busy_cycles"}, nb, exp_lat);
    endtask

    task automatic issue(input vec_t v, input string name);
        exp_t e;
        e.r = v.r; e.z = v.z; e.c = v.c;
        @(posedge clk); #1;
        if (v.w16) begin
            st16 = 1'b1; a16 = v.a; b16 = v.b; sel16 = v.sel;
            q16.push_back(e);
        end else begin
            st8 = 1'b1; a8 = v.a[7:0]; b8 = v.b[7:0]; sel8 = v.sel;
            q8.push_back(e);
        end
        @(posedge clk); #1;
        st8 = 1'b0; st16 = 1'b0;
        wait_done(v.w16, v.lat, name);
    endtask

    vec_t vecs[$];

    initial begin
        // {w16, sel, a, b, result, zero, carry, latency}
        vecs.push_back('{0, 3'b000, 16'h12, 16'h34, 16'h34, 0, 0, 0});
        vecs.push_back('{0, 3'b001, 16'd200, 16'd100, 16'h2C, 0, 1, 0});
        vecs.push_back('{0, 3'b001, 16'h10, 16'h20, 16'h30, 0, 0, 0});
        vecs.push_back('{0, 3'b010, 16'hF0, 16'h3C, 16'h30, 0, 0, 0});
        vecs.push_back('{0, 3'b011, 16'hF0, 16'h0C, 16'hFC, 0, 0, 0});
        vecs.push_back('{0, 3'b100, 16'h80, 16'h01, 16'h7F, 0, 1, 0});
        vecs.push_back('{0, 3'b101, 16'h10, 16'h10, 16'h00, 1, 0, 8});
        vecs.push_back('{0, 3'b111, 16'h90, 16'd3, 16'hF2, 0, 0, 3});
        vecs.push_back('{0, 3'b110, 16'h81, 16'd9, 16'h00, 1, 0, 8});
        vecs.push_back('{0, 3'b110, 16'h81, 16'd0, 16'h81, 0, 0, 0});
        vecs.push_back('{0, 3'b110, 16'h01, 16'd7, 16'h80, 0, 0, 7});
        vecs.push_back('{0, 3'b111, 16'h40, 16'd200, 16'h00, 1, 0, 8});
        vecs.push_back('{0, 3'b111, 16'h80, 16'd8, 16'hFF, 0, 0, 8});
        vecs.push_back('{1, 3'b101, 16'h1234, 16'h0010, 16'h2340, 0, 0, 16});
        vecs.push_back('{1, 3'b001, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_result8", {24'd0, res8}, 32'h0);
        check("rst_zero8",   {31'd0, z8},   32'h1);
        check("rst_carry8",  {31'd0, c8},   32'h0);
        check("rst_busy8",   {31'd0, busy8}, 32'h0);
        check("rst_done8",   {31'd0, done8}, 32'h0);
        check("rst_result16", {16'd0, res16}, 32'h0);

        foreach (vecs[i]) issue(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back SUB: two consecutive DONE pulses.
        begin
            exp_t e;
            @(posedge clk); #1;
            st8 = 1'b1; sel8 = 3'b100; a8 = 8'd5; b8 = 8'd5;
            e.r = 16'h00; e.z = 1; e.c = 1; q8.push_back(e);
            @(posedge clk); #1;
            a8 = 8'd3; b8 = 8'd7;
            e.r = 16'hFC; e.z = 0; e.c = 0; q8.push_back(e);
            @(negedge clk);
            check("b2b_done1", {31'd0, done8}, 32'h1);
            @(posedge clk); #1;
            st8 = 1'b0;
            @(negedge clk);
            check("b2b_done2", {31'd0, done8}, 32'h1);
            check("b2b_busy",  {31'd0, busy8}, 32'h0);
            @(negedge clk);
            check("b2b_done_low", {31'd0, done8}, 32'h0);
        end

        // MUL 13x11 with ignored START pulses (and changed DATA1) while busy.
        begin
            exp_t e;
            int nb = 0;
            int n = 0;
            bit seen = 0;
            @(posedge clk); #1;
            st8 = 1'b1; sel8 = 3'b101; a8 = 8'd13; b8 = 8'd11;
            e.r = 16'h8F; e.z = 0; e.c = 0; q8.push_back(e);
            @(posedge clk); #1;
            st8 = 1'b0;
            while (!seen && n < 40) begin
                a8  = 8'hFF;
                st8 = (n == 2 || n == 5);
                @(negedge clk);
                if (busy8) nb++;
                if (done8) seen = 1;
                else n++;
                @(posedge clk); #1;
            end
            st8 = 1'b0;
            check("mul_inject_latency", n, 8);
            check("mul_inject_busy", nb, 8);
            repeat (4) @(negedge clk);
            check("mul_inject_no_extra", q8.size(), 0);
        end

        // Reset in the 4th EXEC cycle of MUL 255x255.
        @(posedge clk); #1;
        st8 = 1'b1; sel8 = 3'b101; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        st8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_result", {24'd0, res8}, 32'h0);
        check("abort_zero",   {31'd0, z8},   32'h1);
        check("abort_busy",   {31'd0, busy8}, 32'h0);
        check("abort_done",   {31'd0, done8}, 32'h0);
        issue('{0, 3'b101, 16'hFF, 16'hFF, 16'h01, 0, 0, 8}, "mul_after_abort");

        repeat (3) @(negedge clk);
        check("sb8_empty",  q8.size(), 0);
        check("sb16_empty", q16.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mc_alu.md
# mc_alu

Parametrised multi-cycle ALU for the single-cycle processor datapath's next revision. It extends the existing FORWARD/ADD/AND/OR unit with SUB, iterative MUL, and iterative logical-left and arithmetic-right shifts. Operands are latched on a START handshake; RESULT, ZERO and CARRY are registered and qualified by a one-cycle DONE pulse. The control unit stalls the PC while BUSY is high.

## Interface
- WIDTH, 8: operand and result width in bits (≥ 2).
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only while idle (BUSY=0).
- DATA1  input  WIDTH  operand A (register file OUT1).
- DATA2  input  WIDTH  operand B (immediate/OUT2 mux); shift amount for shifts.
- SELECT  input  3  opcode: 000 FORWARD (B), 001 ADD, 010 AND, 011 OR, 100 SUB (A−B), 101 MUL (low WIDTH bits of A×B), 110 SLL (A << B), 111 SRA (A >>> B).
- RESULT  output  WIDTH  registered result; holds until the next completion.
- ZERO  output  1  registered; 1 iff RESULT == 0, updated with RESULT.
- CARRY  output  1  ADD: carry-out. SUB: 1 iff A ≥ B unsigned (no borrow). 0 for all other ops.
- BUSY  output  1  high while a multi-cycle op is executing.
- DONE  output  1  one-cycle pulse; RESULT/ZERO/CARRY are valid and newly written.

## Operation
- States: IDLE and EXEC.
- IDLE, START=1 at edge k:
  - Latch DATA1, DATA2 and SELECT.
  - Ops 000–100: write RESULT/ZERO/CARRY at edge k, DONE=1 for the following cycle, stay in IDLE.
  - MUL: clear the accumulator, load the iteration count WIDTH, go to EXEC, BUSY=1.
  - SLL/SRA: shift count s = min(DATA2, WIDTH).
    - s=0: behaves as a single-cycle op, RESULT = A.
    - s>0: go to EXEC with count s.
- EXEC, one iteration per edge:
  - MUL: shift-add, examining one multiplier bit (LSB first) per cycle.
  - SLL: shift left one bit, zero fill.
  - SRA: shift right one bit, replicating the MSB.
  - On the final iteration, write RESULT/ZERO/CARRY, BUSY→0, DONE=1 next cycle, return to IDLE.
- Shift amounts ≥ WIDTH saturate: SLL gives 0; SRA gives all copies of A's MSB.
- All arithmetic is modulo 2^WIDTH. MUL discards the high product half; CARRY=0 for MUL.
- START while BUSY=1 is ignored (not queued). Operand and SELECT changes during EXEC have no effect.
- START in a cycle with DONE=1 is accepted (state is IDLE), so single-cycle ops issue back-to-back at one per cycle.
- DONE is never high while BUSY is high.
- RESET (any state, including mid-EXEC): abort the op and go to IDLE.
  - Reset values: RESULT=0, ZERO=1, CARRY=0, BUSY=0, DONE=0.
  - Latched operands and count are cleared.
  - RESET has priority over START in the same cycle.

## Timing
- Latency from the START edge k to outputs written:
  - Ops 000–100: edge k, DONE high in cycle k+1.
  - MUL: edge k+WIDTH, BUSY high cycles k+1..k+WIDTH, DONE in cycle k+WIDTH+1.
  - SLL/SRA: edge k+s.
- BUSY rises the cycle after the START edge and falls on the completion edge.
- RESULT, ZERO and CARRY change only on completion edges or reset; no combinational path from inputs to outputs.
- The single-cycle throughput path is one add/subtract, within one clock period of the datapath.

## Test plan
- Reset, then ADD 200+100 (WIDTH=8) -> RESULT=0x2C, CARRY=1, ZERO=0, DONE high exactly the one cycle after the START edge, BUSY never high.
- SUB 5−5, then back-to-back SUB 3−7 on the next cycle -> first RESULT=0x00, ZERO=1, CARRY=1; second RESULT=0xFC, ZERO=0, CARRY=0; two consecutive DONE pulses.
- MUL 13×11 -> BUSY high 8 cycles, RESULT=0x8F, CARRY=0; START pulses injected during BUSY (with a changed DATA1) are ignored and produce no extra DONE.
- SRA 0x90 by 3 -> RESULT=0xF2 after 3 EXEC cycles; SLL 0x81 by 9 -> RESULT=0x00, ZERO=1 after 8 cycles; SLL 0x81 by 0 -> RESULT=0x81, single-cycle.
- RESET asserted in the 4th EXEC cycle of MUL 255×255 -> next cycle RESULT=0, ZERO=1, BUSY=0, DONE=0; a subsequent MUL 255×255 completes with RESULT=0x01.
- WIDTH=16 regression: MUL 0x1234×0x0010 -> RESULT=0x2340 after 16 cycles; ADD 0xFFFF+1 -> RESULT=0, ZERO=1, CARRY=1.
